// File: rtl/ram64_arbiter_if.sv
// Requester and RAM64 port bundle for ram64_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/RAM environment side.
interface ram64_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          done0;
  logic [DW-1:0] rdata0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          done1;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] ram_in;
  logic [AW-1:0] ram_address;
  logic          ram_load;
  logic [DW-1:0] ram_out;
  logic          busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_out,
    output gnt0, done0, rdata0, gnt1, done1, rdata1,
    output ram_in, ram_address, ram_load, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_out,
    input  gnt0, done0, rdata0, gnt1, done1, rdata1,
    input  ram_in, ram_address, ram_load, busy
  );
endinterface

// File: rtl/ram64_arbiter.sv
// Two-port arbiter/sequencer for a shared 64x16 RAM64 (sync write, comb read).
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module ram64_arbiter #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  ram64_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          take_s;
  logic          win_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic          id_r;
  logic          we_r;
  logic          gnt0_r;
  logic          gnt1_r;
  logic          done0_r;
  logic          done1_r;
  logic          ram_load_r;
  logic          busy_r;
  logic [AW-1:0] ram_address_r;
  logic [DW-1:0] ram_in_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;
`ifndef ARB_FIXED_PRIO_EN
  logic          last_r;
`endif

  // Winner selection and mux of the winning command
  always_comb begin
    win_s = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    if (bus.req0) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
`else
    if (bus.req0 && bus.req1) begin
      win_s = ~last_r;
    end else if (bus.req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
`endif
    if (win_s) begin
      sel_we_s    = bus.we1;
      sel_addr_s  = bus.addr1;
      sel_wdata_s = bus.wdata1;
    end else begin
      sel_we_s    = bus.we0;
      sel_addr_s  = bus.addr0;
      sel_wdata_s = bus.wdata0;
    end
  end

  // Next-state logic; arbitration happens in both IDLE and DONE
  always_comb begin
    state_nxt_s = state_r;
    take_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.req0 || bus.req1) begin
          take_s      = 1'b1;
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        state_nxt_s = DONE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, latched command and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      id_r          <= 1'b0;
      we_r          <= 1'b0;
      gnt0_r        <= 1'b0;
      gnt1_r        <= 1'b0;
      done0_r       <= 1'b0;
      done1_r       <= 1'b0;
      ram_load_r    <= 1'b0;
      busy_r        <= 1'b0;
      ram_address_r <= {AW{1'b0}};
      ram_in_r      <= {DW{1'b0}};
      rdata0_r      <= {DW{1'b0}};
      rdata1_r      <= {DW{1'b0}};
`ifndef ARB_FIXED_PRIO_EN
      last_r        <= 1'b1;
`endif
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
      gnt0_r     <= take_s & ~win_s;
      gnt1_r     <= take_s & win_s;
      ram_load_r <= take_s & sel_we_s;
      done0_r    <= (state_r == ACCESS) & ~id_r;
      done1_r    <= (state_r == ACCESS) & id_r;
      if (take_s) begin
        id_r          <= win_s;
        we_r          <= sel_we_s;
        ram_address_r <= sel_addr_s;
        ram_in_r      <= sel_wdata_s;
`ifndef ARB_FIXED_PRIO_EN
        last_r        <= win_s;
`endif
      end
      // Combinational RAM read is captured at the edge ending ACCESS
      if ((state_r == ACCESS) && !we_r) begin
        if (id_r) begin
          rdata1_r <= bus.ram_out;
        end else begin
          rdata0_r <= bus.ram_out;
        end
      end
    end
  end

  assign bus.gnt0        = gnt0_r;
  assign bus.gnt1        = gnt1_r;
  assign bus.done0       = done0_r;
  assign bus.done1       = done1_r;
  assign bus.rdata0      = rdata0_r;
  assign bus.rdata1      = rdata1_r;
  assign bus.ram_load    = ram_load_r;
  assign bus.ram_address = ram_address_r;
  assign bus.ram_in      = ram_in_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_ram64_arbiter.sv
// Self-checking bench for ram64_arbiter: directed steps plus random single accesses
// against a word-level memory/arbitration reference model.
module tb_ram64_arbiter;
  localparam int DW = 16;
  localparam int AW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram64_arbiter_if #(.DW(DW), .AW(AW)) bus ();
  ram64_arbiter #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // RAM64 behaviour: synchronous write, combinational read
  logic [DW-1:0] ram_mem [64];
  always @(posedge clk) begin
    if (bus.ram_load) ram_mem[bus.ram_address] <= bus.ram_in;
  end
  assign bus.ram_out = ram_mem[bus.ram_address];

  logic [DW-1:0] ref_mem [64];
  bit            ref_valid [64];
  logic [DW-1:0] ref_rdata [2];
  bit            last_ref;
  int            tests = 0;
  int            fails = 0;

  function automatic bit exp_winner(bit r0, bit r1);
`ifdef ARB_FIXED_PRIO_EN
    return r0 ? 1'b0 : 1'b1;
`else
    if (r0 && r1) return !last_ref;
    return r1;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic gnt_of(bit id);
    return id ? bus.gnt1 : bus.gnt0;
  endfunction
  function automatic logic done_of(bit id);
    return id ? bus.done1 : bus.done0;
  endfunction
  function automatic logic [DW-1:0] rdata_of(bit id);
    return id ? bus.rdata1 : bus.rdata0;
  endfunction

  task automatic set_req(bit id, bit v, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    if (id) begin
      bus.req1 = v; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = v; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    chk("rst_ctl", {26'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.ram_load, bus.busy}, 32'd0);
    chk("rst_ram", {10'd0, bus.ram_address, bus.ram_in}, 32'd0);
    chk("rst_rdata", {bus.rdata0, bus.rdata1}, 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    last_ref     = 1'b1;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
  endtask

  task automatic do_single(bit id, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    bit w;
    w = exp_winner(!id, id);
    set_req(id, 1'b1, we, a, d);
    tick();
    chk("gnt", gnt_of(w), 1'b1);
    chk("gnt_other", gnt_of(!w), 1'b0);
    chk("acc_load", bus.ram_load, we);
    chk("acc_addr", bus.ram_address, a);
    if (we) chk("acc_wdata", bus.ram_in, d);
    chk("acc_busy", bus.busy, 1'b1);
    last_ref = w;
    set_req(id, 1'b0, 1'b0, '0, '0);
    tick();
    if (we) begin
      ref_mem[a]   = d;
      ref_valid[a] = 1'b1;
    end else begin
      ref_rdata[w] = ref_mem[a];
    end
    chk("done", done_of(w), 1'b1);
    chk("done_other", done_of(!w), 1'b0);
    chk("done_ctl", {bus.ram_load, gnt_of(w), bus.busy}, 3'b001);
    chk("rdata_win", rdata_of(w), ref_rdata[w]);
    chk("rdata_other", rdata_of(!w), ref_rdata[!w]);
    tick();
    chk("idle", {bus.busy, bus.done0, bus.done1}, 3'b000);
  endtask

  // Both requesters hold reads (req0 @0, req1 @63) for n consecutive grants
  task automatic tie_run(int n);
    bit w;
    logic [AW-1:0] a;
    set_req(1'b0, 1'b1, 1'b0, 6'd0, 16'h0000);
    set_req(1'b1, 1'b1, 1'b0, 6'd63, 16'h0000);
    for (int k = 0; k < n; k++) begin
      w = exp_winner(1'b1, 1'b1);
      a = w ? 6'd63 : 6'd0;
      tick();
      chk("tie_gnt", {bus.gnt0, bus.gnt1}, {!w, w});
      chk("tie_addr", bus.ram_address, a);
      chk("tie_busy", {bus.busy, bus.ram_load}, 2'b10);
      last_ref = w;
      if (k == n - 1) begin
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
      end
      tick();
      ref_rdata[w] = ref_mem[a];
      chk("tie_done", {bus.done0, bus.done1}, {!w, w});
      chk("tie_rdata", rdata_of(w), ref_rdata[w]);
    end
    tick();
    chk("tie_idle", bus.busy, 1'b0);
  endtask

  initial begin
    bit id;
    bit we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    #1;
    do_reset();
    tick();
    chk("idle_after_rst", bus.busy, 1'b0);

    do_single(1'b0, 1'b1, 6'd5, 16'hBEEF);
    do_single(1'b1, 1'b0, 6'd5, 16'h0000);
    chk("rd_beef", bus.rdata1, 16'hBEEF);
    do_single(1'b0, 1'b1, 6'd0, 16'h1234);
    do_single(1'b1, 1'b1, 6'd63, 16'hA5C3);
    tie_run(6);

    do_reset();
    tie_run(4);

    for (int i = 0; i < 24; i++) begin
      id = 1'($urandom_range(1, 0));
      we = 1'($urandom_range(1, 0));
      d  = 16'($urandom);
      a  = 6'($urandom_range(63, 0));
      if (!we) begin
        for (int t = 0; t < 64 && !ref_valid[a]; t++) a = 6'($urandom_range(63, 0));
        if (!ref_valid[a]) a = 6'd5;
      end
      do_single(id, we, a, d);
    end

    // Back-to-back re-issue by requester 0
    set_req(1'b0, 1'b1, 1'b0, 6'd63, 16'h0000);
    tick();
    chk("b2b_gnt1", bus.gnt0, 1'b1);
    last_ref = 1'b0;
    tick();
    ref_rdata[0] = ref_mem[63];
    chk("b2b_done1", bus.done0, 1'b1);
    chk("b2b_rdata", bus.rdata0, ref_rdata[0]);
    tick();
    chk("b2b_gnt2", {bus.gnt0, bus.busy}, 2'b11);
    chk("b2b_addr", bus.ram_address, 6'd63);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    chk("b2b_done2", bus.done0, 1'b1);
    tick();
    chk("b2b_idle", bus.busy, 1'b0);

    // Reset during a write ACCESS; commit of that write is not examined
    set_req(1'b0, 1'b1, 1'b1, 6'd10, 16'h5A5A);
    tick();
    chk("mid_load", bus.ram_load, 1'b1);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {bus.ram_load, bus.gnt0, bus.busy}, 3'b000);
    chk("mid_rst_addr", bus.ram_address, 6'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    last_ref     = 1'b1;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    tick();
    chk("mid_idle", {bus.busy, bus.done0, bus.done1}, 3'b000);
    do_single(1'b1, 1'b1, 6'd10, 16'hC0DE);
    do_single(1'b0, 1'b0, 6'd10, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram64_arbiter.md
Name: ram64_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer for one shared 64-word x 16-bit RAM64 instance.
  - The RAM64 has a synchronous write on `ram_load` and a combinational read.
- Two requesters, e.g. CPU data port and a DMA/loader, issue single-word read or write commands.
- The block latches the winning command, drives the RAM port for exactly one cycle, and returns read data with a completion pulse.

Parameters:
- DW, 16, data width of the RAM word and requester data buses.
- AW, 6, address width (64 words).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 command request.
- we0  input  1  requester 0 write enable (1 = write, 0 = read).
- addr0  input  AW  requester 0 word address.
- wdata0  input  DW  requester 0 write data.
- gnt0  output  1  command from requester 0 accepted; one-cycle pulse.
- done0  output  1  requester 0 access complete; one-cycle pulse.
- rdata0  output  DW  requester 0 read data; valid from done0 onward.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1: identical set for requester 1.
- ram_in  output  DW  write data to RAM64.
- ram_address  output  AW  address to RAM64.
- ram_load  output  1  write strobe to RAM64.
- ram_out  input  DW  read data from RAM64 (combinational on ram_address).
- busy  output  1  high in ACCESS and DONE states.

Behaviour:
- Reset (async, rst_n low): all outputs go to 0 immediately.
  - State becomes IDLE.
  - Last-served pointer is set to 1, so requester 0 wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, at a clock edge:
  - If any req is high, pick a winner, latch its we/addr/wdata and the winner ID, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not served last wins.
  - The pointer updates to the winner when the command is latched.
- ACCESS (exactly 1 cycle):
  - ram_address = latched addr and ram_in = latched wdata.
  - ram_load = latched we. The write commits at the edge ending ACCESS.
  - gnt of the winner is high for this cycle only.
  - At the edge ending ACCESS, for a read, rdata of the winner is loaded from ram_out. Go to DONE.
- DONE (1 cycle):
  - done of the winner is high; ram_load = 0.
  - At the edge ending DONE, arbitrate exactly as in IDLE.
  - A pending req goes back to ACCESS (back-to-back). Otherwise go to IDLE.
- Throughput: 1 access per 2 cycles under continuous load.
- Latency from req sampled high to done: 2 cycles if the block is idle when req is sampled.
- Requester obligations:
  - Hold req/we/addr/wdata stable until gnt is seen.
  - Drive req low in the cycle after gnt (the DONE cycle) unless a new command is intended. A req still high during DONE is taken as a new request.
- Outside ACCESS: ram_load = 0. ram_address and ram_in hold their last driven values (0 after reset).
- rdata:
  - rdata0/rdata1 hold their last read value until the next read by the same requester.
  - Writes never change rdata.
- Simultaneous req0 and req1 both held continuously: grants strictly alternate 0,1,0,1...
- Reset asserted during ACCESS: ram_load drops immediately and no gnt/done is issued.
  - The write may or may not commit depending on the RAM's clock relation; the bench must not check it.

Optional Feature:
- ARB_FIXED_PRIO_EN.
  - Defined: requester 0 always wins ties. Requester 1 is served only when req0 is low at the arbitration edge. The pointer is unused.
  - Undefined: round-robin as specified above.

Test Plan:
- Reset, then req0=1, we0=1, addr0=6'd5, wdata0=16'hBEEF -> gnt0 high in cycle 1, ram_load=1 with ram_address=5 in the same cycle, done0 in cycle 2, busy=1 for those 2 cycles.
- After the write above, req1 read at addr1=5 -> done1 pulses and rdata1=16'hBEEF; rdata0 is unchanged.
- req0 and req1 both held high with reads at addresses 0 and 63 -> grants 0,1,0,1, each every 2 cycles, with no idle cycle between accesses. With ARB_FIXED_PRIO_EN defined -> only gnt0 pulses.
- Simultaneous first request after reset -> requester 0 wins; the next tie -> requester 1 wins.
- rst_n pulled low mid-ACCESS of a write -> ram_load, gnt and busy go 0 asynchronously; after release the block is IDLE and the next request is served normally.
- Single read at address 63, then req0 held high through DONE -> a second gnt0 follows at cycle 3 (back-to-back re-issue).
